// File: rtl/mem_if_pkg.sv
// ----------------------------------------------------------------------------
// mem_if_pkg
//   Shared definitions for the cache-to-memory arbiter: default block address
//   and data widths, arbiter state encoding, memory operation encoding and the
//   grant-select helper.
// ----------------------------------------------------------------------------
package mem_if_pkg;

   localparam int ADDR_W_DEF = 28;   // block address (word address >> 2)
   localparam int DATA_W_DEF = 128;  // 4 x 32-bit words

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

   // Returns 1 when the D-cache wins the grant. D wins whenever it requests,
   // unless both request and the I-cache is preferred this round.
   function automatic logic arb_pick(input logic i_req,
                                     input logic d_req,
                                     input logic prefer_i);
      return d_req & ~(i_req & prefer_i);
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter between the I-cache and D-cache block interfaces and a
//   single shared slow memory. One cache is granted at a time; its block read
//   or write is captured at grant and forwarded unchanged until mem_ready.
//
//   Optional feature (macro ARB_ROUND_ROBIN_EN):
//     defined   - a last-grant bit makes ties go to the port not granted last
//                 (reset value = I, so D wins the first tie).
//     undefined - fixed D-over-I priority, no last-grant bit.
//
// Ports:
//   clk, proc_reset        clock (rising edge), async active-high reset
//   i_read/i_write/i_addr/i_wdata   I-cache request, i_rdata/i_ready return
//   d_read/d_write/d_addr/d_wdata   D-cache request, d_rdata/d_ready return
//   mem_read/mem_write/mem_addr/mem_wdata  memory request
//   mem_rdata/mem_ready     memory response
// ----------------------------------------------------------------------------
module mem_arbiter
   import mem_if_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   op_t               op_r;
   op_t               sel_op;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              i_req;
   logic              d_req;
   logic              prefer_i;
   logic              d_wins;
   logic              capture;
   logic              granted;

   assign i_req = i_read | i_write;
   assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;   // 1: D was granted most recently, 0: I (reset value)

   assign prefer_i = last_d;

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         last_d <= 1'b0;
      end else if (capture) begin
         last_d <= d_wins;
      end
   end
`else
   assign prefer_i = 1'b0;
`endif

   assign d_wins = arb_pick(i_req, d_req, prefer_i);

   // Write takes precedence when read and write are both raised on one port.
   always_comb begin
      sel_op = OP_READ;
      if (d_wins) begin
         if (d_write) sel_op = OP_WRITE;
      end else begin
         if (i_write) sel_op = OP_WRITE;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            // A mem_ready arriving here is stale and deliberately ignored.
            if (i_req | d_req) begin
               capture   = 1'b1;
               state_nxt = d_wins ? GRANT_D : GRANT_I;
            end
         end
         GRANT_I, GRANT_D: begin
            // Requester inputs are not looked at until the grant completes.
            if (mem_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state   <= IDLE;
         op_r    <= OP_READ;
         addr_r  <= '0;
         wdata_r <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            op_r    <= sel_op;
            addr_r  <= d_wins ? d_addr  : i_addr;
            wdata_r <= d_wins ? d_wdata : i_wdata;
         end
      end
   end

   assign granted = (state == GRANT_I) || (state == GRANT_D);

   // Strobes drop combinationally in the ready cycle so memory never sees a
   // second request before the arbiter has returned to IDLE.
   assign mem_read  = granted & (op_r == OP_READ)  & ~mem_ready;
   assign mem_write = granted & (op_r == OP_WRITE) & ~mem_ready;
   assign mem_addr  = granted ? addr_r  : '0;
   assign mem_wdata = granted ? wdata_r : '0;

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;
   assign i_ready = mem_ready & (state == GRANT_I);
   assign d_ready = mem_ready & (state == GRANT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed testbench for mem_arbiter. Expected grant order adapts to the
//   ARB_ROUND_ROBIN_EN build option.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          proc_reset;
   logic          i_read, i_write, d_read, d_write;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .i_read     (i_read),
      .i_write    (i_write),
      .i_addr     (i_addr),
      .i_wdata    (i_wdata),
      .i_rdata    (i_rdata),
      .i_ready    (i_ready),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_ready    (d_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   logic [DW-1:0] rd_blk;
   logic          exp_d;
   logic [AW-1:0] ia, da;

   initial begin
      proc_reset = 1'b1;
      i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
      d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      repeat (2) @(posedge clk);
      #2;
      // ---------------- reset state
      chk("rst_mem_read",  DW'(mem_read),  '0);
      chk("rst_mem_write", DW'(mem_write), '0);
      chk("rst_mem_addr",  DW'(mem_addr),  '0);
      chk("rst_mem_wdata", mem_wdata,      '0);
      chk("rst_i_ready",   DW'(i_ready),   '0);
      chk("rst_d_ready",   DW'(d_ready),   '0);
      proc_reset = 1'b0;
      tick;

      // ---------------- simultaneous I read / D write: D first, then I
      i_read = 1; i_addr = 28'h40;
      d_write = 1; d_addr = 28'h80; d_wdata = {32{4'h5}};
      tick;
      chk("sim_d_write", DW'(mem_write), DW'(1));
      chk("sim_d_read0", DW'(mem_read),  '0);
      chk("sim_d_addr",  DW'(mem_addr),  DW'(28'h80));
      chk("sim_d_wdata", mem_wdata,      {32{4'h5}});
      tick;
      mem_ready = 1; d_write = 0;
      #1;
      chk("sim_d_ready", DW'(d_ready), DW'(1));
      chk("sim_i_ready0", DW'(i_ready), '0);
      tick;
      mem_ready = 0;
      chk("sim_bubble_rd", DW'(mem_read),  '0);
      chk("sim_bubble_wr", DW'(mem_write), '0);
      tick;
      chk("sim_i_read", DW'(mem_read), DW'(1));
      chk("sim_i_addr", DW'(mem_addr), DW'(28'h40));
      mem_ready = 1; i_read = 0;
      #1;
      chk("sim_i_ready", DW'(i_ready), DW'(1));
      chk("sim_d_ready0", DW'(d_ready), '0);
      tick;
      mem_ready = 0;
      tick;

      // ---------------- D-only read, ready after 8 cycles
      d_read = 1; d_addr = 28'h0000123;
      tick;
      chk("dr_mem_read", DW'(mem_read), DW'(1));
      chk("dr_mem_addr", DW'(mem_addr), DW'(28'h0000123));
      chk("dr_d_ready0", DW'(d_ready),  '0);
      repeat (7) tick;
      rd_blk = 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0004;
      mem_rdata = rd_blk; mem_ready = 1; d_read = 0;
      #1;
      chk("dr_d_ready",   DW'(d_ready),  DW'(1));
      chk("dr_mem_read0", DW'(mem_read), '0);
      chk("dr_i_ready0",  DW'(i_ready),  '0);
      chk("dr_d_rdata",   d_rdata,       rd_blk);
      chk("dr_i_rdata",   i_rdata,       rd_blk);
      tick;
      mem_ready = 0;
      chk("dr_idle_rd", DW'(mem_read), '0);
      tick;

      // ---------------- D write-back then allocate, I pending
      d_write = 1; d_addr = 28'h10; d_wdata = {32{4'hA}};
      tick;
      chk("wb_write", DW'(mem_write), DW'(1));
      chk("wb_addr",  DW'(mem_addr),  DW'(28'h10));
      i_read = 1; i_addr = 28'h40;
      tick;
      mem_ready = 1; d_write = 0; d_read = 1; d_addr = 28'h20;
      #1;
      chk("wb_d_ready", DW'(d_ready), DW'(1));
      tick;
      mem_ready = 0;
      chk("wb_bubble", DW'(mem_read | mem_write), '0);
      tick;
      // Fixed: D keeps winning. Round-robin: D was last, so I wins.
      exp_d = !RR;
      chk("wb_next_rd",   DW'(mem_read), DW'(1));
      chk("wb_next_addr", DW'(mem_addr), exp_d ? DW'(28'h20) : DW'(28'h40));
      mem_ready = 1;
      if (exp_d) d_read = 0; else i_read = 0;
      #1;
      chk("wb_next_rdy", DW'({i_ready, d_ready}), exp_d ? DW'(2'b01) : DW'(2'b10));
      tick;
      mem_ready = 0;
      tick;
      chk("wb_other_addr", DW'(mem_addr), exp_d ? DW'(28'h40) : DW'(28'h20));
      mem_ready = 1; i_read = 0; d_read = 0;
      #1;
      chk("wb_other_rdy", DW'({i_ready, d_ready}), exp_d ? DW'(2'b10) : DW'(2'b01));
      tick;
      mem_ready = 0;
      tick;

      // ---------------- illegal read+write on D, spurious ready in IDLE
      d_read = 1; d_write = 1; d_addr = 28'h7; d_wdata = {32{4'h3}};
      tick;
      chk("il_write", DW'(mem_write), DW'(1));
      chk("il_read0", DW'(mem_read),  '0);
      chk("il_addr",  DW'(mem_addr),  DW'(28'h7));
      mem_ready = 1; d_read = 0; d_write = 0;
      #1;
      chk("il_d_ready", DW'(d_ready), DW'(1));
      tick;
      mem_ready = 0;
      tick;
      mem_ready = 1;
      #1;
      chk("spur_ready", DW'({i_ready, d_ready}), '0);
      tick;
      mem_ready = 0;
      chk("spur_idle", DW'({mem_read, mem_write}), '0);
      tick;

      // ---------------- reset asserted mid-transaction (between edges)
      i_read = 1; i_addr = 28'h55;
      tick;
      chk("rm_read", DW'(mem_read), DW'(1));
      chk("rm_addr", DW'(mem_addr), DW'(28'h55));
      i_read = 0;
      #1;
      proc_reset = 1;
      #1;
      chk("rm_read0", DW'(mem_read), '0);
      chk("rm_addr0", DW'(mem_addr), '0);
      tick;
      proc_reset = 0;
      mem_ready = 1;
      #1;
      chk("rm_late_ready", DW'({i_ready, d_ready}), '0);
      tick;
      mem_ready = 0;
      chk("rm_idle", DW'({mem_read, mem_write}), '0);

      // ---------------- both ports requesting back-to-back, 4 transactions
      ia = 28'h100; da = 28'h200;
      i_read = 1; i_addr = ia; d_read = 1; d_addr = da;
      for (int k = 0; k < 4; k++) begin
         tick;
         exp_d = RR ? ((k % 2) == 0) : 1'b1;
         chk("bb_read", DW'(mem_read), DW'(1));
         chk("bb_addr", DW'(mem_addr), exp_d ? DW'(da) : DW'(ia));
         tick;
         mem_ready = 1;
         if (exp_d) d_read = 0; else i_read = 0;
         #1;
         chk("bb_ready", DW'({i_ready, d_ready}), exp_d ? DW'(2'b01) : DW'(2'b10));
         tick;
         mem_ready = 0;
         chk("bb_bubble", DW'(mem_read), '0);
         if (exp_d) begin
            da = da + 28'h1; d_addr = da; d_read = 1;
         end else begin
            ia = ia + 28'h1; i_addr = ia; i_read = 1;
         end
      end
      i_read = 0; d_read = 0;
      tick;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache miss/write-back interfaces and feeds the single shared slow memory.
- Grants one cache at a time and forwards its block read or write unchanged.
- Routes mem_ready back to the granted cache only.
- Uses the same hold-until-ready handshake as the caches: requester holds request until it sees ready, then drops it in the same cycle.

Parameters:
ADDR_W, 28, block address width (word address minus 2-bit offset)
DATA_W, 128, block width (4 x 32-bit words)

Ports:
clk  input  1  system clock, rising edge
proc_reset  input  1  asynchronous, active-high reset
i_read  input  1  I-cache block read request
i_write  input  1  I-cache block write request
i_addr  input  ADDR_W  I-cache block address
i_wdata  input  DATA_W  I-cache write block
i_rdata  output  DATA_W  read block to I-cache
i_ready  output  1  completion pulse to I-cache
d_read  input  1  D-cache block read request
d_write  input  1  D-cache block write request
d_addr  input  ADDR_W  D-cache block address
d_wdata  input  DATA_W  D-cache write block
d_rdata  output  DATA_W  read block to D-cache
d_ready  output  1  completion pulse to D-cache
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory block address
mem_wdata  output  DATA_W  memory write block
mem_rdata  input  DATA_W  memory read block
mem_ready  input  1  memory completion pulse

Behaviour:
- Clocking and reset: one clock, clk. proc_reset is asynchronous and active-high; all state clears immediately on assertion.
- States:
  - IDLE: no grant.
  - GRANT_I: I-cache owns memory.
  - GRANT_D: D-cache owns memory.
- Registers: state, op (read/write), addr_r, wdata_r, last-grant bit (optional feature only).
- Request decode:
  - Port request = read | write.
  - If read and write are both high on one port, treat it as a write (illegal case, defined behaviour).
- IDLE:
  - If any request is present at the clock edge, capture the winner's op, addr and wdata, then move to GRANT_x.
  - Default priority is fixed: D beats I.
  - A mem_ready seen in IDLE is ignored.
- GRANT_x:
  - mem_read = op_is_read & ~mem_ready; mem_write = op_is_write & ~mem_ready.
  - mem_addr = addr_r; mem_wdata = wdata_r. All four are 0 in IDLE.
  - On mem_ready, go to IDLE. Requester inputs are not re-sampled during a grant.
- Return path:
  - i_rdata = d_rdata = mem_rdata, always broadcast.
  - i_ready = mem_ready & (state==GRANT_I).
  - d_ready = mem_ready & (state==GRANT_D).
  - Both readys are combinational.
- Latency:
  - Request first high before edge N → mem strobe high from cycle N+1.
  - Ready in cycle M → earliest next grant captured at edge M+1, strobe at M+2. This is one bubble cycle minimum between transactions.
- D-cache write-back then allocate: the D write completes, the arbiter returns to IDLE, and the following D read competes normally. A pending I request may win only under round-robin.
- Starvation: under fixed priority, I is served only when d_read/d_write are low in IDLE.
- Reset mid-transaction: all strobes drop to 0 asynchronously and state goes to IDLE. Any memory response after reset is ignored.
- Reset values: all outputs 0; state IDLE; addr_r, wdata_r and last-grant all 0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a last-grant register records the most recently granted port. When both ports request in IDLE, the port not granted last wins. Reset value of last-grant = I, so D wins the first tie.
- Undefined: fixed D-over-I priority, and no last-grant register is built.

Decomposition:
- Shared package mem_if_pkg:
  - state encoding localparams: IDLE=0, GRANT_I=1, GRANT_D=2.
  - ADDR_W/DATA_W defaults.
  - op encoding (OP_READ=0, OP_WRITE=1).
- No sub-module needed. The grant-select logic stays inline; a separate arb_pick function in the package is acceptable.

Test Plan:
- D-only read: d_read=1, d_addr=28'h0000123. Expect mem_read=1, mem_addr=28'h0000123 from the next cycle. Memory returns 128'hDEAD_BEEF_0000_0001_..._0004 with mem_ready after 8 cycles. Expect d_ready=1 that cycle, mem_read=0 that cycle, i_ready=0.
- Simultaneous I read (addr 0x40) and D write (addr 0x80, wdata all 5s), fixed priority:
  - D is granted first: mem_write=1, mem_wdata=128'h5555…; after ready, IDLE for 1 cycle.
  - I is granted next: mem_read with mem_addr=0x40.
- Round-robin build, both ports requesting continuously for 4 transactions: grant order is D, I, D, I.
- D write-back then allocate: D write to 0x10 completes, then the D cache raises d_read to 0x20 while i_read is pending. Under fixed priority, expect D read 0x20 next.
- Reset mid-transaction: assert proc_reset between clock edges during GRANT_I. Expect mem_read=0 immediately, without waiting for an edge. A later mem_ready pulse produces no i_ready/d_ready.
- Illegal d_read=d_write=1 with addr 0x7: the arbiter issues mem_write only. A spurious mem_ready in IDLE produces no readys.
